// File: rtl/vecmac_accum.sv
// rtl/vecmac_accum.sv - product accumulator with one-entry valid/ready result register
// Optional build macro: VECMAC_ACCUM_SAT_EN (saturating instead of wrapping sums).
module vecmac_accum #(
  parameter int PROD_W = 16,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              busy,
  output logic              err_overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [LEN_W-1:0]   count, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   count_inc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_add;
  logic [ACC_W-1:0]   sum;
  logic               complete;
  logic               out_free;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
`ifdef VECMAC_ACCUM_SAT_EN
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign eff_len   = (vec_len == '0) ? LEN_W'(1) : vec_len;
  assign count_inc = count + LEN_W'(1);
  assign prod_ext  = ACC_W'(in_product);
  assign sum_add   = acc_add(acc, prod_ext);
  assign out_free  = !out_valid || out_ready;
  assign busy      = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    count_d  = count;
    len_d    = len_q;
    complete = 1'b0;
    sum      = '0;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          len_d = eff_len;
          if (eff_len == LEN_W'(1)) begin
            complete = 1'b1;
            sum      = prod_ext;
          end else begin
            acc_d   = prod_ext;
            count_d = LEN_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (count_inc == len_q) begin
            complete = 1'b1;
            sum      = sum_add;
            acc_d    = '0;
            count_d  = '0;
            state_d  = IDLE;
          end else begin
            acc_d   = sum_add;
            count_d = count_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A result landing on an occupied, unaccepted register is lost and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_acc      <= '0;
      err_overflow <= 1'b0;
    end else if (clr) begin
      out_valid    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (complete && out_free) begin
      out_acc   <= sum;
      out_valid <= 1'b1;
    end else if (complete) begin
      err_overflow <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vecmac_accum.sv
// tb/tb_vecmac_accum.sv - directed self-checking bench for vecmac_accum
module tb_vecmac_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  vec_len = 8'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_product = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_acc;
  logic        busy;
  logic        err_overflow;

  logic        clr18 = 1'b0;
  logic [7:0]  vec_len18 = 8'd0;
  logic        in_valid18 = 1'b0;
  logic [15:0] in_product18 = 16'd0;
  logic        out_valid18;
  logic        out_ready18 = 1'b1;
  logic [17:0] out_acc18;
  logic        busy18;
  logic        err18;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vecmac_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vec_len(vec_len),
    .in_valid(in_valid), .in_product(in_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .busy(busy), .err_overflow(err_overflow)
  );

  vecmac_accum #(.PROD_W(16), .LEN_W(8), .ACC_W(18)) dut18 (
    .clk(clk), .rst_n(rst_n), .clr(clr18), .vec_len(vec_len18),
    .in_valid(in_valid18), .in_product(in_product18),
    .out_valid(out_valid18), .out_ready(out_ready18), .out_acc(out_acc18),
    .busy(busy18), .err_overflow(err18)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic elem(input logic [15:0] p);
    in_valid   = 1'b1;
    in_product = p;
    tick();
  endtask

  task automatic idle;
    in_valid = 1'b0;
    tick();
  endtask

  logic [17:0] exp18;

  initial begin
    #2;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_acc", 32'(out_acc), 0);
    check("rst busy", 32'(busy), 0);
    check("rst err", 32'(err_overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: length 4, vec_len change mid-vector ignored
    out_ready = 1'b1;
    vec_len = 8'd4;
    in_valid = 1'b1; in_product = 16'd1;
    check("t1 busy e1", 32'(busy), 0);
    tick();
    vec_len = 8'd2;
    check("t1 busy e2", 32'(busy), 1);
    elem(16'd2);
    check("t1 busy e3", 32'(busy), 1);
    check("t1 no early valid", 32'(out_valid), 0);
    elem(16'd3);
    check("t1 busy e4", 32'(busy), 1);
    elem(16'd4);
    check("t1 out_valid", 32'(out_valid), 1);
    check("t1 out_acc", 32'(out_acc), 10);
    check("t1 busy after", 32'(busy), 0);
    idle();
    check("t1 valid one cycle", 32'(out_valid), 0);
    check("t1 acc held", 32'(out_acc), 10);

    // 2: vec_len 0 acts as 1
    vec_len = 8'd0;
    elem(16'd7);
    check("t2 v1", 32'(out_valid), 1);
    check("t2 acc1", 32'(out_acc), 7);
    check("t2 busy1", 32'(busy), 0);
    elem(16'd9);
    check("t2 v2", 32'(out_valid), 1);
    check("t2 acc2", 32'(out_acc), 9);
    check("t2 busy2", 32'(busy), 0);
    idle();
    check("t2 drained", 32'(out_valid), 0);

    // 3: overflow drop then clr
    out_ready = 1'b0;
    vec_len = 8'd3;
    elem(16'd1); elem(16'd1); elem(16'd1);
    check("t3 v", 32'(out_valid), 1);
    check("t3 acc", 32'(out_acc), 3);
    check("t3 err0", 32'(err_overflow), 0);
    elem(16'd2); elem(16'd2); elem(16'd2);
    in_valid = 1'b0;
    check("t3 acc kept", 32'(out_acc), 3);
    check("t3 err", 32'(err_overflow), 1);
    check("t3 still valid", 32'(out_valid), 1);
    clr = 1'b1; in_valid = 1'b1; in_product = 16'd50;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("t3 clr valid", 32'(out_valid), 0);
    check("t3 clr err", 32'(err_overflow), 0);
    check("t3 clr acc", 32'(out_acc), 3);
    check("t3 clr busy", 32'(busy), 0);

    // 5: accept and completion in same cycle
    vec_len = 8'd2;
    elem(16'd4); elem(16'd5);
    check("t5 v1", 32'(out_valid), 1);
    check("t5 acc1", 32'(out_acc), 9);
    elem(16'd6);
    out_ready = 1'b1;
    elem(16'd7);
    check("t5 v2", 32'(out_valid), 1);
    check("t5 acc2", 32'(out_acc), 13);
    check("t5 err", 32'(err_overflow), 0);
    idle();
    check("t5 drained", 32'(out_valid), 0);

    // 6: async reset mid-vector
    vec_len = 8'd4;
    elem(16'd100); elem(16'd100);
    in_valid = 1'b0;
    check("t6 busy pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst acc", 32'(out_acc), 0);
    tick();
    rst_n = 1'b1;
    tick();
    elem(16'd5); elem(16'd5); elem(16'd5); elem(16'd5);
    check("t6 v", 32'(out_valid), 1);
    check("t6 acc", 32'(out_acc), 20);
    idle();

    // 4: 18-bit accumulator wrap / saturate
`ifdef VECMAC_ACCUM_SAT_EN
    exp18 = 18'd262143;
`else
    exp18 = 18'd62981;
`endif
    vec_len18 = 8'd5;
    in_valid18 = 1'b1; in_product18 = 16'd65025;
    for (int i = 0; i < 5; i++) tick();
    in_valid18 = 1'b0;
    check("t4 v", 32'(out_valid18), 1);
    check("t4 acc", 32'(out_acc18), 32'(exp18));
    check("t4 err", 32'(err18), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vecmac_accum.md
Name: vecmac_accum

Overview:
Accumulation stage directly downstream of the 8x8 Wallace multiplier in the int8 vector MAC. It consumes the multiplier's 16-bit unsigned product stream (valid-only, no backpressure) and sums a programmable number of products into one dot-product result. Each completed result is held in a one-entry output register with a valid/ready handshake toward the consumer.

Parameters:
PROD_W, 16, width of the incoming product.
LEN_W, 8, width of the vector-length field.
ACC_W, 24, accumulator and result width; must be >= PROD_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
clr  input  1  synchronous clear: drops the partial sum and the pending result, and clears err_overflow.
vec_len  input  LEN_W  number of products per vector; 0 is treated as 1; sampled on the first element of each vector.
in_valid  input  1  in_product is valid this cycle. There is no ready; the block must accept it.
in_product  input  PROD_W  unsigned product from the multiplier.
out_valid  output  1  out_acc holds an unaccepted result.
out_ready  input  1  consumer accepts out_acc when out_valid && out_ready.
out_acc  output  ACC_W  completed dot-product sum.
busy  output  1  a vector is partially accumulated (state ACCUM).
err_overflow  output  1  sticky flag: a completed result was dropped because the output register was occupied.

Behaviour:
- Reset values: out_valid=0, out_acc=0, busy=0, err_overflow=0, internal acc=0, count=0, len_q=0, state=IDLE.
- Arithmetic: unsigned. Product is zero-extended to ACC_W. The sum wraps modulo 2^ACC_W (see Optional Feature). With the defaults, 255 x 65025 = 16,581,375, which fits in 24 bits, so no wrap occurs.
- IDLE, in_valid=1:
  - len_q <= max(vec_len,1).
  - If len_q==1 the vector completes in this cycle with sum = in_product, and the state stays IDLE.
  - Otherwise acc <= in_product, count <= 1, state -> ACCUM.
- ACCUM, in_valid=1:
  - acc <= acc + in_product, count <= count + 1.
  - When count+1 == len_q the vector completes with sum = acc + in_product; then acc <= 0, count <= 0, state -> IDLE.
- ACCUM, in_valid=0: hold. Gaps between elements are allowed and unlimited.
- vec_len changes while in ACCUM have no effect until the next vector starts.
- Completion, with the output register free (out_valid=0, or out_valid && out_ready in the same cycle):
  - out_acc <= sum and out_valid <= 1 on the next edge.
  - Latency is one cycle from the last element's in_valid cycle.
  - A simultaneous accept and completion loads the new result with no bubble and no error.
- Completion, with the output register occupied and not accepted: the new result is dropped, err_overflow <= 1, and out_acc/out_valid are unchanged.
- Accept without completion: out_valid <= 0; out_acc holds its last value.
- out_acc is stable while out_valid && !out_ready.
- clr=1 (takes priority over in_valid in the same cycle):
  - acc=0, count=0, state=IDLE, out_valid=0, err_overflow=0.
  - out_acc is left unchanged.
  - An in_valid in the same cycle is discarded.
- Asynchronous reset mid-vector: all state returns to reset values immediately; the partial sum is lost.
- Back-to-back vectors: an element arriving in the cycle after completion starts the new vector from IDLE.

Optional Feature:
Macro: VECMAC_ACCUM_SAT_EN.
- Defined: each addition saturates at 2^ACC_W-1 and stays saturated for the rest of the vector. A completed result equal to all-ones indicates possible saturation.
- Undefined: plain modulo-2^ACC_W wrap. Ports and timing are identical in both builds.

Test Plan:
1. vec_len=4; products 1,2,3,4 on consecutive cycles; out_ready=1 -> out_valid for exactly 1 cycle, 1 cycle after the 4th element, with out_acc=10; busy high from the 2nd to the 4th element cycle.
2. vec_len=0; products 7 then 9 -> two results, out_acc=7 then 9, each 1 cycle after its element; busy never asserts.
3. vec_len=3; out_ready=0; two vectors (1,1,1 and 2,2,2) -> out_acc holds 3, the second result is dropped, and err_overflow=1. Then clr -> out_valid=0 and err_overflow=0.
4. ACC_W=18, vec_len=5; five products of 65025 -> out_acc=62981 without the macro, out_acc=262143 with VECMAC_ACCUM_SAT_EN.
5. vec_len=2, with out_valid pending: the consumer asserts out_ready in the same cycle the next vector completes -> the new sum is loaded, out_valid stays 1, and err_overflow stays 0.
6. rst_n asserted after 2 of 4 elements, then released; stimulus resumes with a fresh vector 5,5,5,5 -> out_acc=20, with no contribution from the earlier partial sum.
